battle_fsm: RTL

- Parametrised successor to the battle top-level state machine: sequences MENU -> DODGE -> ACTION -> ATTACK -> DODGE ... -> WIN.
- Adds a selectable action menu with wrap-around cursor, monster HP countdown with saturating subtract, and per-phase configurable timeouts.
- Replaces the separate slow clock with a single-clock `tick` enable.
- Sits between keyConverter output and the player/bullet/attack-bar blocks.

---
 rtl/battle_fsm_if.sv | 41 ++++
 rtl/battle_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// battle_fsm_if : event inputs and control outputs of the battle sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface battle_fsm_if #(
  parameter int HP_W = 8
);
  logic            tick;
  logic [3:0]      key;
  logic            is_death;
  logic            dmg_valid;
  logic [HP_W-1:0] dmg_amount;
  logic            heal;
  logic            atk_pass;
  logic [HP_W-1:0] atk_dmg;

  logic [7:0]      state;
  logic [15:0]     player_instr;
  logic            is_move;
  logic            start_dmg;
  logic [HP_W-1:0] mon_hp;
  logic [3:0]      sel;
  logic            atk_start;
  logic            atk_reset;
  logic            atk_button;
  logic            win;

  modport master (
    output tick, key, is_death, dmg_valid, dmg_amount, heal, atk_pass, atk_dmg,
    input  state, player_instr, is_move, start_dmg, mon_hp, sel,
           atk_start, atk_reset, atk_button, win
  );

  modport slave (
    input  tick, key, is_death, dmg_valid, dmg_amount, heal, atk_pass, atk_dmg,
    output state, player_instr, is_move, start_dmg, mon_hp, sel,
           atk_start, atk_reset, atk_button, win
  );
endinterface
`default_nettype wire

// File: rtl/battle_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// battle_fsm : MENU/DODGE/ACTION/ATTACK/WIN sequencer with tick-based timeouts
// Rev 1.0
// ---------------------------------------------------------------------------
module battle_fsm #(
  parameter int HP_W         = 8,
  parameter int MON_HP_MAX   = 100,
  parameter int DODGE_TICKS  = 7,
  parameter int ACTION_TICKS = 7,
  parameter int ATTACK_TICKS = 3,
  parameter int NUM_ACTIONS  = 4,
  parameter int HEAL_AMT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  battle_fsm_if.slave bus
);

  localparam logic [3:0] PAGE_MENU   = 4'h1;
  localparam logic [3:0] PAGE_WIN    = 4'h2;
  localparam logic [3:0] PAGE_DODGE  = 4'h9;
  localparam logic [3:0] PAGE_ATTACK = 4'hA;
  localparam logic [3:0] PAGE_ACTION = 4'hB;

  localparam logic [3:0] KEY_W     = 4'd1;
  localparam logic [3:0] KEY_A     = 4'd2;
  localparam logic [3:0] KEY_D     = 4'd4;
  localparam logic [3:0] KEY_SPACE = 4'd8;

  localparam logic [3:0] OP_HPY = 4'h1;
  localparam logic [3:0] OP_DPY = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h5;

  localparam logic [7:0]      DODGE_LIM  = 8'(DODGE_TICKS);
  localparam logic [7:0]      ACTION_LIM = 8'(ACTION_TICKS);
  localparam logic [7:0]      ATTACK_LIM = 8'(ATTACK_TICKS);
  localparam logic [3:0]      SEL_LAST   = 4'(NUM_ACTIONS - 1);
  localparam logic [7:0]      HEAL_ARG   = 8'(HEAL_AMT);
  localparam logic [HP_W-1:0] HP_LOAD    = HP_W'(MON_HP_MAX);

  logic [3:0]      page_q, page_d;
  logic [3:0]      sub_q, sub_d;
  logic [3:0]      key_q;
  logic [3:0]      sel_q, sel_d;
  logic [7:0]      tick_cnt_q, tick_cnt_d;
  logic [HP_W-1:0] mon_hp_q, mon_hp_d;
  logic [15:0]     player_instr_q, player_instr_d;
  logic            is_move_q, is_move_d;
  logic            start_dmg_q, start_dmg_d;
  logic            atk_start_q, atk_start_d;
  logic            atk_reset_q, atk_reset_d;
  logic            atk_button_q, atk_button_d;
  logic            win_q, win_d;

  logic            press;
  logic            space_press;
  logic            a_press;
  logic            d_press;
  logic            timeout;
  logic            stopped_d;
  logic [HP_W-1:0] hp_after_atk;

  // Edge-detected key: a held key counts only on the cycle it first appears
  assign press       = (bus.key != 4'd0) && (bus.key != key_q);
  assign space_press = press && (bus.key == KEY_SPACE);
  assign a_press     = press && (bus.key == KEY_A);
  assign d_press     = press && (bus.key == KEY_D);

  assign hp_after_atk = (bus.atk_dmg >= mon_hp_q) ? '0 : (mon_hp_q - bus.atk_dmg);

  always_comb begin
    timeout = 1'b0;
    case (page_q)
      PAGE_DODGE:  timeout = (tick_cnt_q >= DODGE_LIM);
      PAGE_ACTION: timeout = (tick_cnt_q >= ACTION_LIM);
      PAGE_ATTACK: timeout = (tick_cnt_q >= ATTACK_LIM);
      default:     timeout = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q         <= PAGE_MENU;
      sub_q          <= 4'h0;
      key_q          <= 4'h0;
      sel_q          <= 4'h0;
      tick_cnt_q     <= 8'h00;
      mon_hp_q       <= '0;
      player_instr_q <= 16'h0000;
      is_move_q      <= 1'b0;
      start_dmg_q    <= 1'b0;
      atk_start_q    <= 1'b0;
      atk_reset_q    <= 1'b1;
      atk_button_q   <= 1'b0;
      win_q          <= 1'b0;
    end else begin
      page_q         <= page_d;
      sub_q          <= sub_d;
      key_q          <= bus.key;
      sel_q          <= sel_d;
      tick_cnt_q     <= tick_cnt_d;
      mon_hp_q       <= mon_hp_d;
      player_instr_q <= player_instr_d;
      is_move_q      <= is_move_d;
      start_dmg_q    <= start_dmg_d;
      atk_start_q    <= atk_start_d;
      atk_reset_q    <= atk_reset_d;
      atk_button_q   <= atk_button_d;
      win_q          <= win_d;
    end
  end

  // Next-page logic
  always_comb begin
    page_d = page_q;
    case (page_q)
      PAGE_MENU: begin
        if (space_press) page_d = PAGE_DODGE;
      end
      PAGE_DODGE: begin
        if (bus.is_death)  page_d = PAGE_MENU;
        else if (timeout)  page_d = PAGE_ACTION;
      end
      PAGE_ACTION: begin
        if (timeout)          page_d = PAGE_DODGE;
        else if (space_press) page_d = (sel_q == 4'h0) ? PAGE_ATTACK : PAGE_DODGE;
      end
      PAGE_ATTACK: begin
        if (bus.atk_pass) page_d = (hp_after_atk == '0) ? PAGE_WIN : PAGE_DODGE;
        else if (timeout) page_d = PAGE_DODGE;
      end
      PAGE_WIN: begin
        if (space_press) page_d = PAGE_MENU;
      end
      default: page_d = PAGE_MENU;
    endcase
  end

  // Registered-output logic
  always_comb begin
    sel_d          = sel_q;
    mon_hp_d       = mon_hp_q;
    player_instr_d = player_instr_q;
    is_move_d      = 1'b0;
    start_dmg_d    = 1'b0;
    atk_button_d   = 1'b0;
    atk_start_d    = atk_start_q;
    atk_reset_d    = atk_reset_q;
    stopped_d      = sub_q[0];

    case (page_q)
      PAGE_MENU: begin
        if (space_press) begin
          mon_hp_d = HP_LOAD;
          sel_d    = 4'h0;
        end
      end
      PAGE_DODGE: begin
        if (bus.is_death) begin
          sel_d = sel_q;
        end else if (timeout) begin
          sel_d = 4'h0;
        end else if (bus.dmg_valid) begin
          player_instr_d = bus.heal ? {OP_HPY, HEAL_ARG, 4'h0}
                                    : {OP_DPY, 8'(bus.dmg_amount), 4'h0};
          start_dmg_d    = 1'b1;
        end else if ((bus.key >= KEY_W) && (bus.key <= KEY_D)) begin
          player_instr_d = {OP_MOV, 4'h0, bus.key - 4'd1, 4'h0};
          is_move_d      = 1'b1;
        end else begin
          player_instr_d = 16'h0000;
        end
      end
      PAGE_ACTION: begin
        if (timeout) begin
          sel_d = sel_q;
        end else if (space_press) begin
          if (sel_q == 4'h0) begin
            atk_start_d = 1'b1;
            atk_reset_d = 1'b0;
            stopped_d   = 1'b0;
          end
        end else if (a_press) begin
          sel_d = (sel_q == 4'h0) ? SEL_LAST : (sel_q - 4'd1);
        end else if (d_press) begin
          sel_d = (sel_q == SEL_LAST) ? 4'h0 : (sel_q + 4'd1);
        end
      end
      PAGE_ATTACK: begin
        if (bus.atk_pass) begin
          mon_hp_d = hp_after_atk;
        end else if (timeout) begin
          mon_hp_d = mon_hp_q;
        end else if (space_press && !sub_q[0]) begin
          atk_button_d = 1'b1;
          stopped_d    = 1'b1;
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase

    // The attack bar is parked whenever ATTACK is left, whatever the cause
    if ((page_q == PAGE_ATTACK) && (page_d != PAGE_ATTACK)) begin
      atk_start_d = 1'b0;
      atk_reset_d = 1'b1;
    end

    win_d = (page_d == PAGE_WIN);

    if (page_d != page_q)
      tick_cnt_d = 8'h00;
    else if (bus.tick && (tick_cnt_q != 8'hFF))
      tick_cnt_d = tick_cnt_q + 8'h01;
    else
      tick_cnt_d = tick_cnt_q;

    case (page_d)
      PAGE_ACTION: sub_d = sel_d;
      PAGE_ATTACK: sub_d = {3'b000, (page_q == PAGE_ATTACK) ? stopped_d : 1'b0};
      default:     sub_d = 4'h0;
    endcase
  end

  assign bus.state        = {page_q, sub_q};
  assign bus.player_instr = player_instr_q;
  assign bus.is_move      = is_move_q;
  assign bus.start_dmg    = start_dmg_q;
  assign bus.mon_hp       = mon_hp_q;
  assign bus.sel          = sel_q;
  assign bus.atk_start    = atk_start_q;
  assign bus.atk_reset    = atk_reset_q;
  assign bus.atk_button   = atk_button_q;
  assign bus.win          = win_q;

endmodule
`default_nettype wire
